sram_audio_streamer: RTL

SRAM_AUDIO_STREAMER -- requirements
Module: sram_audio_streamer

---
 rtl/sram_audio_streamer.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_audio_streamer.sv
// sram_audio_streamer: plays interleaved multi-channel audio frames out of an
// asynchronous 16-bit SRAM. Frames are prefetched into a small FIFO and one
// frame is presented on sample_out every DIV clock cycles.
module sram_audio_streamer #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV        = 1042
) (
  input  logic                     Clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W-1:0]        end_addr,
  output logic [ADDR_W-1:0]        SRAM_ADDR,
  output logic                     SRAM_CE_N,
  output logic                     SRAM_OE_N,
  output logic                     SRAM_WE_N,
  output logic                     SRAM_UB_N,
  output logic                     SRAM_LB_N,
  input  logic [15:0]              SRAM_DQ,
  output logic [NUM_CH*DATA_W-1:0] sample_out,
  output logic                     sample_tick,
  output logic                     busy,
  output logic                     underrun,
  output logic                     cfg_err
);

  localparam int FRAME_W = NUM_CH * DATA_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TICK_W  = $clog2(DIV);

  typedef enum logic [2:0] {
    IDLE,
    READ_ADDR,
    READ_DATA,
    WAIT_SPACE,
    DRAIN
  } state_t;

  state_t              state;
  logic                ready;        // low for the first edge after reset release
  logic [ADDR_W-1:0]   cur_addr;
  logic [ADDR_W-1:0]   base_lat;
  logic [ADDR_W-1:0]   end_lat;
  logic [CH_W-1:0]     ch_idx;
  logic [FRAME_W-1:0]  frame_asm;
  logic                sram_sel_n;   // shared CE/OE/UB/LB strobe

  logic [FRAME_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    fifo_count;
  logic [TICK_W-1:0]   tick_cnt;

  // Control decode shared by the sequencer, FIFO and output stage.
  logic                stop_hit;
  logic                start_req;
  logic                range_ok;
  logic                start_go;
  logic                last_slot;
  logic                tick_hit;
  logic                fifo_empty;
  logic                fifo_full;
  logic                push;
  logic                pop;
  logic [CNT_W-1:0]    count_nxt;
  logic                past_end;
  logic [ADDR_W-1:0]   next_frame_addr;
  logic [FRAME_W-1:0]  frame_next;

  assign stop_hit   = stop && (state != IDLE);
  assign start_req  = (state == IDLE) && ready && start && !stop;
  // One extra bit so a range ending at the top of memory does not wrap.
  assign range_ok   = ({1'b0, base_addr} + (ADDR_W+1)'(NUM_CH - 1)) <= {1'b0, end_addr};
  assign start_go   = start_req && range_ok;
  assign last_slot  = (ch_idx == CH_W'(NUM_CH - 1));
  assign tick_hit   = (state != IDLE) && (tick_cnt == TICK_W'(DIV - 1));
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign push       = (state == READ_DATA) && last_slot && !stop;
  assign pop        = tick_hit && !fifo_empty && !stop;
  assign count_nxt  = fifo_count + CNT_W'(push) - CNT_W'(pop);

  // cur_addr holds the last word of the frame being completed, so the next
  // frame's last word is cur_addr + NUM_CH.
  assign past_end        = ({1'b0, cur_addr} + (ADDR_W+1)'(NUM_CH)) > {1'b0, end_lat};
  assign next_frame_addr = past_end ? base_lat : cur_addr + ADDR_W'(1);

  assign SRAM_CE_N = sram_sel_n;
  assign SRAM_OE_N = sram_sel_n;
  assign SRAM_UB_N = sram_sel_n;
  assign SRAM_LB_N = sram_sel_n;
  assign SRAM_WE_N = 1'b1;

  // Frame assembly view with the word currently on the bus dropped into its slot.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    frame_next = frame_asm;
    frame_next[ch_idx*DATA_W +: DATA_W] = SRAM_DQ[DATA_W-1:0];
  end

  // Read sequencer: walks the address range one word every two cycles.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      state      <= IDLE;
      ready      <= 1'b0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
      cur_addr   <= '0;
      base_lat   <= '0;
      end_lat    <= '0;
      ch_idx     <= '0;
      frame_asm  <= '0;
      SRAM_ADDR  <= '0;
      sram_sel_n <= 1'b1;
    end else begin
      ready   <= 1'b1;
      cfg_err <= start_req && !range_ok;
      if (stop_hit) begin
        state      <= IDLE;
        busy       <= 1'b0;
        ch_idx     <= '0;
        sram_sel_n <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start_req) begin
              base_lat <= base_addr;
              end_lat  <= end_addr;
              cur_addr <= base_addr;
              ch_idx   <= '0;
              if (range_ok) begin
                state      <= READ_ADDR;
                busy       <= 1'b1;
                SRAM_ADDR  <= base_addr;
                sram_sel_n <= 1'b0;
              end
            end
          end

          READ_ADDR: begin
            state <= READ_DATA;
          end

          READ_DATA: begin
            frame_asm <= frame_next;
            if (!last_slot) begin
              ch_idx    <= ch_idx + CH_W'(1);
              cur_addr  <= cur_addr + ADDR_W'(1);
              SRAM_ADDR <= cur_addr + ADDR_W'(1);
              state     <= READ_ADDR;
            end else begin
              ch_idx <= '0;
              if (past_end && !loop_en) begin
                state      <= DRAIN;
                sram_sel_n <= 1'b1;
              end else begin
                cur_addr <= next_frame_addr;
                // Never start a frame the FIFO has no room to accept.
                if (count_nxt == CNT_W'(FIFO_DEPTH)) begin
                  state      <= WAIT_SPACE;
                  sram_sel_n <= 1'b1;
                end else begin
                  state     <= READ_ADDR;
                  SRAM_ADDR <= next_frame_addr;
                end
              end
            end
          end

          WAIT_SPACE: begin
            if (!fifo_full) begin
              state      <= READ_ADDR;
              SRAM_ADDR  <= cur_addr;
              sram_sel_n <= 1'b0;
            end
          end

          DRAIN: begin
            if (tick_hit && fifo_empty) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end

          default: begin
            state      <= IDLE;
            busy       <= 1'b0;
            sram_sel_n <= 1'b1;
          end
        endcase
      end
    end
  end

  // Frame FIFO storage, written with the completed frame on the last word.
  always_ff @(posedge Clk) begin
    // NOTE: the storage array has no reset; validity is tracked entirely by
    // the pointers and count, which are reset.
    if (push) begin
      fifo_mem[wr_ptr] <= frame_next;
    end
  end

  // FIFO pointers and occupancy; stop flushes everything in one edge.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (stop_hit) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= count_nxt;
    end
  end

  // Sample-rate divider and output stage: pops one frame per tick.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt    <= '0;
      sample_out  <= '0;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      sample_tick <= 1'b0;
      if (stop_hit) begin
        tick_cnt   <= '0;
        sample_out <= '0;
      end else if (state == IDLE) begin
        tick_cnt <= '0;
        if (start_go) underrun <= 1'b0;
      end else if (tick_hit) begin
        tick_cnt <= '0;
        if (!fifo_empty) begin
          sample_out  <= fifo_mem[rd_ptr];
          sample_tick <= 1'b1;
        end else if (state != DRAIN) begin
          // Starved mid-stream: repeat the previous frame and flag it.
          underrun    <= 1'b1;
          sample_tick <= 1'b1;
        end
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
    end
  end

endmodule
